// File: rtl/delay_slot_scheduler.sv
// delay_slot_scheduler: picks cand0, cand1 or a NOP bubble for each branch delay slot
// and keeps saturating per-source fill statistics.
module delay_slot_scheduler #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             cand0_valid,
    input  logic [31:0]      cand0_instr,
    input  logic             cand1_valid,
    input  logic [31:0]      cand1_instr,
    input  logic             branch_done,
    output logic             kill_cand1,
    output logic             slot_valid,
    output logic [1:0]       slot_sel,
    output logic [31:0]      slot_instr,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_cand0,
    output logic [CNT_W-1:0] cnt_cand1,
    output logic [CNT_W-1:0] cnt_nop
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_CAND, WAIT_RES} state_t;

    state_t           state_q, state_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [4:0]       rs_q, rs_d, rt_q, rt_d;
    logic             slot_valid_q, slot_valid_d;
    logic [1:0]       slot_sel_q, slot_sel_d;
    logic [31:0]      slot_instr_q, slot_instr_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d, cntn_q, cntn_d;
    logic             capture, decide, timeout, elig0, elig1;
    logic [1:0]       sel;
    logic [4:0]       br_rs, br_rt, d0, d1;

    function automatic logic is_cti(input logic [31:0] i);
        return i[31:26] inside {6'h02, 6'h03, 6'h04, 6'h05} || (i[31:26] == 6'h00 && i[5:0] == 6'h08);
    endfunction

    function automatic logic [4:0] dest(input logic [31:0] i);
        if (is_cti(i))
            return 5'd0;
        if (i[31:26] == 6'h00)
            return i[15:11];
        if (i[31:29] == 3'b001 || i[31:26] == 6'h23)
            return i[20:16];
        return 5'd0;
    endfunction

    function automatic logic is_mem(input logic [31:0] i);
        return i[31:26] == 6'h23 || i[31:26] == 6'h2B;
    endfunction

    // A zero destination never conflicts, so r0 reads are never hazards.
    function automatic logic hits(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
        return d != 5'd0 && (d == a || d == b);
    endfunction

    always_comb begin
        br_rs   = (state_q == IDLE) ? id_instr[25:21] : rs_q;
        br_rt   = (state_q == IDLE) ? id_instr[20:16] : rt_q;
        d0      = dest(cand0_instr);
        d1      = dest(cand1_instr);
        elig0   = cand0_valid && !is_cti(cand0_instr) && cand0_instr != 32'h0 && !hits(d0, br_rs, br_rt);
        elig1   = cand1_valid && !is_cti(cand1_instr) && cand1_instr != 32'h0 && !hits(d1, br_rs, br_rt)
                  && !hits(d1, cand0_instr[25:21], cand0_instr[20:16]) && !hits(d1, d0, d0)
                  && !hits(d0, cand1_instr[25:21], cand1_instr[20:16])
                  && !(is_mem(cand0_instr) && is_mem(cand1_instr));
        sel     = !cand0_valid ? 2'b00 : elig0 ? 2'b01 : elig1 ? 2'b10 : 2'b00;
        capture = state_q == IDLE && id_valid && is_cti(id_instr) && !stall && !flush;
        timeout = wait_cnt_q == WW'(MAX_WAIT - 1);
        decide  = !reset && !flush && ((capture && cand0_valid) || (state_q == WAIT_CAND && (cand0_valid || timeout)));
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        rs_d       = capture ? id_instr[25:21] : rs_q;
        rt_d       = capture ? id_instr[20:16] : rt_q;
        if (flush) begin
            state_d    = IDLE;
            wait_cnt_d = '0;
        end else if (decide) begin
            state_d    = WAIT_RES;
            wait_cnt_d = '0;
        end else if (capture) begin
            state_d    = WAIT_CAND;
            wait_cnt_d = '0;
        end else if (state_q == WAIT_CAND) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end else if (state_q == WAIT_RES && branch_done) begin
            state_d = IDLE;
        end
        slot_valid_d = decide;
        slot_sel_d   = decide ? sel : slot_sel_q;
        slot_instr_d = !decide ? slot_instr_q : sel == 2'b01 ? cand0_instr : sel == 2'b10 ? cand1_instr : 32'h0;
        cnt0_d = cnt0_q + CNT_W'(decide && sel == 2'b01 && cnt0_q != '1);
        cnt1_d = cnt1_q + CNT_W'(decide && sel == 2'b10 && cnt1_q != '1);
        cntn_d = cntn_q + CNT_W'(decide && sel == 2'b00 && cntn_q != '1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            slot_valid_q <= 1'b0;
            slot_sel_q   <= 2'b00;
            slot_instr_q <= 32'h0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            cntn_q       <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            slot_valid_q <= slot_valid_d;
            slot_sel_q   <= slot_sel_d;
            slot_instr_q <= slot_instr_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
            cntn_q       <= cntn_d;
        end
    end

    assign kill_cand1 = decide && sel == 2'b10;
    assign slot_valid = slot_valid_q;
    assign slot_sel   = slot_sel_q;
    assign slot_instr = slot_instr_q;
    assign busy       = state_q != IDLE;
    assign cnt_cand0  = cnt0_q;
    assign cnt_cand1  = cnt1_q;
    assign cnt_nop    = cntn_q;
endmodule

// File: tb/tb_delay_slot_scheduler.sv
// tb_delay_slot_scheduler: directed scenarios then random traffic, each cycle compared
// against a behavioural model of the fill rules.
module tb_delay_slot_scheduler;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 3;
    localparam int CMAX     = 7;

    logic clk = 1'b1;
    logic reset, stall, flush, id_valid, cand0_valid, cand1_valid, branch_done;
    logic [31:0] id_instr, cand0_instr, cand1_instr;
    logic kill_cand1, slot_valid, busy;
    logic [1:0] slot_sel;
    logic [31:0] slot_instr;
    logic [CNT_W-1:0] cnt_cand0, cnt_cand1, cnt_nop;

    always #5 clk = ~clk;

    delay_slot_scheduler #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_instr(id_instr),
        .id_valid(id_valid), .cand0_valid(cand0_valid), .cand0_instr(cand0_instr),
        .cand1_valid(cand1_valid), .cand1_instr(cand1_instr), .branch_done(branch_done),
        .kill_cand1(kill_cand1), .slot_valid(slot_valid), .slot_sel(slot_sel),
        .slot_instr(slot_instr), .busy(busy), .cnt_cand0(cnt_cand0), .cnt_cand1(cnt_cand1),
        .cnt_nop(cnt_nop)
    );

    int checks = 0, passed = 0, fails = 0;

    // Model: a branch is either absent, waiting for cand0, or decided and awaiting resolution.
    bit m_waiting, m_resolving;
    int m_wait, m_rs, m_rt, m_sel, m_cnt[3];
    bit m_sv;
    logic [31:0] m_instr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit cti(input logic [31:0] i);
        int op = int'(i[31:26]);
        return op == 2 || op == 3 || op == 4 || op == 5 || (op == 0 && i[5:0] == 6'h08);
    endfunction

    function automatic int dst(input logic [31:0] i);
        int op = int'(i[31:26]);
        if (cti(i)) return 0;
        if (op == 0) return int'(i[15:11]);
        if ((op >= 8 && op <= 15) || op == 'h23) return int'(i[20:16]);
        return 0;
    endfunction

    function automatic bit mem(input logic [31:0] i);
        return i[31:26] == 6'h23 || i[31:26] == 6'h2B;
    endfunction

    function automatic bit usable(input logic [31:0] i, input int rs, input int rt);
        int d = dst(i);
        return !cti(i) && i != 0 && (d == 0 || (d != rs && d != rt));
    endfunction

    function automatic int choose(input logic [31:0] c0, input bit v1, input logic [31:0] c1, input int rs, input int rt);
        int d0 = dst(c0), d1 = dst(c1);
        int rs0 = int'(c0[25:21]), rt0 = int'(c0[20:16]), rs1 = int'(c1[25:21]), rt1 = int'(c1[20:16]);
        if (usable(c0, rs, rt)) return 1;
        if (!v1 || !usable(c1, rs, rt) || (mem(c0) && mem(c1))) return 0;
        if (d1 != 0 && (d1 == rs0 || d1 == rt0 || d1 == d0)) return 0;
        if (d0 != 0 && (d0 == rs1 || d0 == rt1)) return 0;
        return 2;
    endfunction

    task automatic cyc(input bit rst, input bit fl, input bit st, input bit iv, input logic [31:0] id,
                       input bit c0v, input logic [31:0] c0, input bit c1v, input logic [31:0] c1, input bit bd);
        bit dec = 0;
        int sel = 0;
        reset = rst; flush = fl; stall = st; id_valid = iv; id_instr = id;
        cand0_valid = c0v; cand0_instr = c0; cand1_valid = c1v; cand1_instr = c1; branch_done = bd;
        @(negedge clk);
        chk("busy", busy, m_waiting || m_resolving);
        if (rst || fl) begin
        end else if (!m_waiting && !m_resolving) begin
            if (iv && cti(id) && !st) begin
                m_rs = int'(id[25:21]);
                m_rt = int'(id[20:16]);
                if (c0v) dec = 1;
                else begin m_waiting = 1; m_wait = 0; end
            end
        end else if (m_waiting) begin
            if (c0v || m_wait == MAX_WAIT - 1) dec = 1;
            else m_wait++;
        end
        if (dec) sel = c0v ? choose(c0, c1v, c1, m_rs, m_rt) : 0;
        chk("kill_cand1", kill_cand1, dec && sel == 2);
        if (rst) begin
            m_waiting = 0; m_resolving = 0; m_sv = 0; m_sel = 0; m_instr = 0; m_cnt = '{0, 0, 0};
        end else if (fl) begin
            m_waiting = 0; m_resolving = 0; m_sv = 0;
        end else begin
            if (m_resolving && bd) m_resolving = 0;
            if (dec) begin
                m_waiting = 0; m_resolving = 1; m_sel = sel;
                m_instr = sel == 1 ? c0 : sel == 2 ? c1 : 0;
                if (m_cnt[sel] < CMAX) m_cnt[sel]++;
            end
            m_sv = dec;
        end
        @(posedge clk);
        #1;
        chk("slot_valid", slot_valid, m_sv);
        chk("slot_sel", slot_sel, m_sel);
        chk("slot_instr", slot_instr, m_instr);
        chk("cnt_cand0", cnt_cand0, m_cnt[1]);
        chk("cnt_cand1", cnt_cand1, m_cnt[2]);
        chk("cnt_nop", cnt_nop, m_cnt[0]);
    endtask

    function automatic logic [31:0] rinstr();
        logic [4:0] a = 5'($urandom_range(0, 7)), b = 5'($urandom_range(0, 7)), c = 5'($urandom_range(0, 7));
        logic [15:0] imm = 16'($urandom);
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return {($urandom_range(0, 1) != 0) ? 6'h02 : 6'h03, 26'($urandom)};
            2: return {6'h04, a, b, imm};
            3: return {6'h05, a, b, imm};
            4: return {6'h00, a, 15'h0, 6'h08};
            5, 6: return {6'h00, a, b, c, 5'h0, 6'h20};
            7: return {6'h08, a, b, imm};
            8: return {6'h23, a, b, imm};
            default: return {6'h2B, a, b, imm};
        endcase
    endfunction

    localparam logic [31:0] BEQ12 = {6'h04, 5'd1, 5'd2, 16'h0010};

    function automatic logic [31:0] add(input int d, input int s, input int t);
        return {6'h00, 5'(s), 5'(t), 5'(d), 5'h0, 6'h20};
    endfunction

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_sel", slot_sel, 2'b00);
        // natural fill, promoted fill, NOP fill
        cyc(0, 0, 0, 1, BEQ12, 1, add(3, 4, 5), 1, add(6, 7, 8), 0);
        chk("t1_sel", slot_sel, 2'b01);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, BEQ12, 1, add(1, 4, 5), 1, add(6, 7, 8), 0);
        chk("t2_sel", slot_sel, 2'b10);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, BEQ12, 1, add(2, 4, 5), 1, add(9, 2, 3), 0);
        chk("t3_instr", slot_instr, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // cand0 never arrives: NOP on 4th waiting cycle
        cyc(0, 0, 0, 1, BEQ12, 0, 0, 0, 0, 0);
        for (int i = 0; i < MAX_WAIT; i++) cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("t4_nop_cnt", cnt_nop, 3'd2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // cand0 arrives on 3rd waiting cycle
        cyc(0, 0, 0, 1, BEQ12, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, add(3, 4, 5), 0, 0, 0);
        chk("t4_late_sel", slot_sel, 2'b01);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // flush while waiting, reset on the decision cycle
        cyc(0, 0, 0, 1, BEQ12, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1, add(3, 4, 5), 0, 0, 0);
        cyc(0, 0, 0, 1, BEQ12, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, add(1, 4, 5), 1, add(6, 7, 8), 0);
        chk("t5_cnt0_zero", cnt_cand0, 3'd0);
        // saturate NOP counter; a second branch during resolution is ignored
        for (int i = 0; i < CMAX + 2; i++) begin
            cyc(0, 0, 0, 1, BEQ12, 1, 32'h0, 0, 0, 0);
            cyc(0, 0, 0, 1, BEQ12, 1, add(3, 4, 5), 1, add(6, 7, 8), 0);
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        end
        chk("t6_sat", cnt_nop, 3'd7);
        chk("t6_ignored", cnt_cand0, 3'd0);
        for (int i = 0; i < 4000; i++)
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 3) != 0, rinstr(), $urandom_range(0, 4) < 3, rinstr(),
                $urandom_range(0, 3) != 0, rinstr(), $urandom_range(0, 3) == 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
